// File: rtl/uart_rx_x4_if.sv
// uart_rx_x4_if: serial-side inputs and byte-side outputs of the x4-oversampled UART receiver.
// The receiver connects through the slave modport. The line/baud source and the byte consumer
// use the master modport.
interface uart_rx_x4_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 baudrateX4;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_error;
  logic                 parity_error;

  modport slave (
    input  baudrateX4,
    input  rx,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_error,
    output parity_error
  );

  modport master (
    output baudrateX4,
    output rx,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_error,
    input  parity_error
  );
endinterface

// File: rtl/uart_rx_x4.sv
// uart_rx_x4: 8N1 byte receiver driven by a 4x-baud square wave, one sample tick per rising edge.
// The start bit is confirmed two ticks after detection. Data, parity and stop bits are sampled
// when the 2-bit sample counter is 3, which falls near mid-bit. Each received byte is presented
// with a one-cycle rx_valid strobe.
// Optional feature: define UART_PARITY_EN to insert a parity bit. PARITY_ODD selects odd (1) or
// even (0) parity. Without the macro, parity_error is tied low.
module uart_rx_x4 #(
  parameter int unsigned DATA_BITS   = 8,  // 5..8
  parameter int unsigned SYNC_STAGES = 2,  // >= 2
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic        clock_in,
  input  logic        reset_n,
  uart_rx_x4_if.slave bus
);

  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_PARITY_EN
    StParity = 3'd4,
`endif
    StStop   = 3'd3
  } state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic                   r_baud;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_cnt;
  logic [1:0]             w_cnt_d;
  logic [2:0]             r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_perr;

  logic w_tick;
  logic w_rx_s;
  logic w_shift_en;
  logic w_stop_en;
  logic w_par_en;
  logic w_par_err;

  // baudrateX4 already lives in the clock_in domain; only its rising edge is needed.
  assign w_tick = bus.baudrateX4 & ~r_baud;
  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Baud edge register and rx synchronizer, preset high so reset never looks like a start bit.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_baud <= 1'b1;
      r_sync <= '1;
    end else begin
      r_baud <= bus.baudrateX4;
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx};
    end
  end

  // Next state plus the strobes that say which bit is being sampled on this tick.
  always_comb begin
    w_state_d  = r_state;
    w_shift_en = 1'b0;
    w_stop_en  = 1'b0;
    w_par_en   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_tick && !w_rx_s) begin
          w_state_d = StStart;
        end
      end
      StStart: begin
        // A line that is high again by now was a glitch, not a start bit.
        if (w_tick && (r_cnt == 2'd1)) begin
          w_state_d = w_rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (w_tick && (r_cnt == 2'd3)) begin
          w_shift_en = 1'b1;
          if (r_bitcnt == LastBit) begin
`ifdef UART_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (w_tick && (r_cnt == 2'd3)) begin
          w_par_en  = 1'b1;
          w_state_d = StStop;
        end
      end
`endif
      StStop: begin
        // Leaving at mid-stop gives IDLE time to catch a back-to-back start edge.
        if (w_tick && (r_cnt == 2'd3)) begin
          w_stop_en = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Sample counter restarts on every state entry and otherwise advances once per tick.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state) begin
      w_cnt_d = 2'd0;
    end else if (w_tick) begin
      w_cnt_d = r_cnt + 2'd1;
    end
  end

  // State register, sample counter, bit counter and data shift register.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_cnt    <= 2'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if ((r_state == StStart) && (w_state_d == StData)) begin
        r_bitcnt <= 3'd0;
      end else if (w_shift_en) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      // Right shift into the MSB so the first data bit ends up in the LSB.
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_PARITY_EN
  localparam logic ParityOdd = (PARITY_ODD != 0);

  logic r_par;

  // Received parity bit, held until the stop bit is judged.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_par <= 1'b0;
    end else if (w_par_en) begin
      r_par <= w_rx_s;
    end
  end

  // Even parity expects the bit to equal the XOR of the data bits; odd parity expects its inverse.
  assign w_par_err = r_par ^ (^r_shift) ^ ParityOdd;
`else
  assign w_par_err = 1'b0;
`endif

  // Frame outcome registered one clock after the stop-bit sample; every strobe lasts one cycle.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      if (w_stop_en) begin
        r_ferr <= ~w_rx_s;
        r_perr <= w_par_err;
        if (w_rx_s && !w_par_err) begin
          r_valid <= 1'b1;
          r_data  <= r_shift;
        end
      end
    end
  end

  assign bus.rx_data      = r_data;
  assign bus.rx_valid     = r_valid;
  assign bus.frame_error  = r_ferr;
  assign bus.parity_error = r_perr;
  assign bus.rx_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_x4.sv
// tb_uart_rx_x4: table-driven frames, hand-written corner cases and random frames for uart_rx_x4.
// Expected results come from frame-level rules: stop bit, parity bit and the last good byte.
module tb_uart_rx_x4;

  localparam int unsigned BitClks = 32;  // 4 ticks of 8 clocks
  localparam logic        ParOdd  = 1'b0;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;

  uart_rx_x4_if #(.DATA_BITS(8)) bus ();

  uart_rx_x4 #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2),
    .PARITY_ODD (0)
  ) dut (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  int unsigned cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Baud source: toggle every 4 clocks, so one tick every 8 clocks.
  initial begin
    bus.baudrateX4 = 1'b0;
    forever begin
      repeat (4) @(negedge clock_in);
      bus.baudrateX4 = ~bus.baudrateX4;
    end
  end

  // Output monitor, sampled on the falling edge.
  int unsigned n_valid = 0;
  int unsigned n_ferr  = 0;
  int unsigned n_perr  = 0;
  int unsigned n_busy  = 0;
  int unsigned valid_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  vq[$];

  always @(negedge clock_in) begin
    if (bus.rx_valid === 1'b1) begin
      check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
      n_valid++;
      valid_cyc = cyc;
      vq.push_back(bus.rx_data);
    end
    if (bus.frame_error === 1'b1) n_ferr++;
    if (bus.parity_error === 1'b1) n_perr++;
    if (bus.rx_busy === 1'b1) n_busy++;
    prev_valid = bus.rx_valid;
  end

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        par_good;
    int unsigned gap;
    logic        exp_valid;
    logic        exp_ferr;
    logic        exp_perr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t        vecs[$];
  int unsigned stop_cyc = 0;
  logic [7:0]  model_data = 8'h00;

  task automatic drive_bit(input logic b, input int unsigned clks);
    bus.rx = b;
    repeat (clks) @(negedge clock_in);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_good);
    logic par;
    par = (^data) ^ ParOdd ^ ~par_good;
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 8; i++) drive_bit(data[i], BitClks);
`ifdef UART_PARITY_EN
    drive_bit(par, BitClks);
`else
    if (par !== 1'b0 && par !== 1'b1) $display("parity bit undefined");
`endif
    stop_cyc = cyc;
    drive_bit(stop, BitClks);
    bus.rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int unsigned v0, f0, p0;
    logic [7:0]  got;
    v0 = n_valid;
    f0 = n_ferr;
    p0 = n_perr;
    send_frame(v.data, v.stop, v.par_good);
    repeat (v.gap) @(negedge clock_in);
    check({tag, "_valid_cnt"}, n_valid - v0, {31'd0, v.exp_valid});
    check({tag, "_ferr_cnt"}, n_ferr - f0, {31'd0, v.exp_ferr});
    check({tag, "_perr_cnt"}, n_perr - p0, {31'd0, v.exp_perr});
    if (v.exp_valid && vq.size() > 0) begin
      got = vq.pop_front();
      check({tag, "_valid_data"}, {24'd0, got}, {24'd0, v.data});
      check_range({tag, "_latency"}, int'(valid_cyc - stop_cyc), 12, 30);
    end
    while (vq.size() > 0) void'(vq.pop_front());
    check({tag, "_rx_data"}, {24'd0, bus.rx_data}, {24'd0, v.exp_data});
    if (v.gap >= 40) check({tag, "_busy_idle"}, {31'd0, bus.rx_busy}, 32'd0);
  endtask

  // Frame-level reference: outcome depends only on the stop bit and parity correctness.
  function automatic vec_t model(input logic [7:0] d, input logic stop, input logic pg,
                                 input int unsigned gap);
    vec_t v;
    v.data      = d;
    v.stop      = stop;
    v.par_good  = pg;
    v.gap       = gap;
    v.exp_valid = stop && pg;
    v.exp_ferr  = !stop;
`ifdef UART_PARITY_EN
    v.exp_perr  = !pg;
`else
    v.exp_perr  = 1'b0;
`endif
    v.exp_data  = v.exp_valid ? d : model_data;
    return v;
  endfunction

  initial begin
    int unsigned v0, f0, b0;
    vec_t        v;
    logic [7:0]  d;
    logic        s, pg;
    int unsigned gap;

    //                data   stop good gap  valid ferr perr  data after
    vecs.push_back('{8'h3C, 1'b1, 1'b1, 40, 1'b1, 1'b0, 1'b0, 8'h3C});
    vecs.push_back('{8'hA5, 1'b0, 1'b1, 64, 1'b0, 1'b1, 1'b0, 8'h3C});
    vecs.push_back('{8'h00, 1'b1, 1'b1,  0, 1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 40, 1'b1, 1'b0, 1'b0, 8'hFF});
    vecs.push_back('{8'h81, 1'b1, 1'b1,  8, 1'b1, 1'b0, 1'b0, 8'h81});
    vecs.push_back('{8'h5A, 1'b1, 1'b1, 40, 1'b1, 1'b0, 1'b0, 8'h5A});
`ifdef UART_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 40, 1'b1, 1'b0, 1'b0, 8'h07});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 40, 1'b0, 1'b0, 1'b1, 8'h07});
`endif

    bus.rx  = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(negedge clock_in);
    check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("reset_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("reset_frame_error", {31'd0, bus.frame_error}, 32'd0);
    check("reset_parity_error", {31'd0, bus.parity_error}, 32'd0);
    reset_n = 1'b1;
    repeat (40) @(negedge clock_in);

    // One-tick low glitch: START is entered then abandoned silently.
    v0 = n_valid;
    f0 = n_ferr;
    b0 = n_busy;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 64);
    check("glitch_valid_cnt", n_valid - v0, 32'd0);
    check("glitch_ferr_cnt", n_ferr - f0, 32'd0);
    check("glitch_busy_seen", {31'd0, (n_busy - b0) > 0}, 32'd1);
    check("glitch_busy_idle", {31'd0, bus.rx_busy}, 32'd0);
    check("glitch_rx_data", {24'd0, bus.rx_data}, 32'd0);

    // Table frames; busy must be high in the middle of the first one.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0) begin
        fork
          run_frame($sformatf("vec%0d", i), vecs[i]);
          begin
            repeat (BitClks * 5) @(negedge clock_in);
            check("busy_mid_frame", {31'd0, bus.rx_busy}, 32'd1);
          end
        join
      end else begin
        run_frame($sformatf("vec%0d", i), vecs[i]);
      end
      model_data = vecs[i].exp_data;
    end

    // Random frames against the frame-level model.
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      s  = ($urandom_range(0, 4) != 0);
`ifdef UART_PARITY_EN
      pg = ($urandom_range(0, 3) != 0);
`else
      pg = 1'b1;
`endif
      gap = s ? $urandom_range(0, 40) : 48 + $urandom_range(0, 16);
      v = model(d, s, pg, gap);
      run_frame($sformatf("rnd%0d", i), v);
      model_data = v.exp_data;
    end

    // Reset during data bit 4 of 0x5A: partial frame vanishes, outputs clear.
    repeat (40) @(negedge clock_in);
    v0 = n_valid;
    f0 = n_ferr;
    d  = 8'h5A;
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BitClks);
    drive_bit(d[4], BitClks / 2);
    reset_n = 1'b0;
    @(negedge clock_in);
    reset_n = 1'b1;
    drive_bit(d[4], BitClks / 2);
    drive_bit(1'b1, 80);
    check("midreset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("midreset_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("midreset_valid_cnt", n_valid - v0, 32'd0);
    check("midreset_ferr_cnt", n_ferr - f0, 32'd0);
    model_data = 8'h00;
    v = model(8'h81, 1'b1, 1'b1, 40);
    run_frame("after_reset", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
